miner_host_master: RTL
======================

MINER_HOST_MASTER -- requirements
Module: miner_host_master

Interface
REQ-001 POLL_INTERVAL, default 16, idle cycles between status polls; legal minimum 2.
REQ-002 TIMEOUT_POLLS, default 1024, status reads before abort; used only with MINER_HOST_TIMEOUT_EN.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle job request.
REQ-006 target  input  256  difficulty target.
REQ-007 message  input  608  block header without nonce.
REQ-008 busy  output  1  job in progress.
REQ-009 done  output  1  one-cycle job-finished pulse.
REQ-010 found  output  1  valid nonce found; held until next start.
REQ-011 timeout  output  1  job aborted by watchdog; held until next start.
REQ-012 foundNonce  output  32  winning nonce; held until next start.
REQ-013 masterAddr  output  5  Avalon word address.
REQ-014 masterWriteData  output  32  Avalon write data.
REQ-015 masterWrite  output  1  write strobe.
REQ-016 masterRead  output  1  read strobe.
REQ-017 masterChipSelect  output  1  high exactly when masterWrite or masterRead is high.
REQ-018 masterReadData  input  32  read data, valid exactly one cycle after masterRead.

Function
REQ-019 Register map: addr 0 status ([0] complete, [1] found); addr 1 control ([0] newTarget, [1] newMsg); addr 2..9 target words, addr 2 = target[31:0]; addr 10 found nonce; addr 11..29 message words, addr 11 = message[31:0].
REQ-020 States: IDLE, CLR_CTRL, WR_TARGET, WR_MSG, SET_CTRL, POLL_WAIT, POLL_RD, POLL_CAP, NONCE_RD, NONCE_CAP, FINISH.
REQ-021 IDLE: start high -> capture target and message, clear found/timeout/foundNonce, go CLR_CTRL; busy high from next cycle.
REQ-022 start while busy is ignored; captured inputs are not updated mid-job.
REQ-023 CLR_CTRL: one write, addr 1, data 0.
REQ-024 WR_TARGET: 8 back-to-back writes, addr 2..9, one per cycle.
REQ-025 WR_MSG: 19 back-to-back writes, addr 11..29, one per cycle.
REQ-026 SET_CTRL: one write, addr 1, data 3; total write phase 29 cycles, no gaps.
REQ-027 POLL_WAIT: count POLL_INTERVAL idle cycles, bus strobes low; then POLL_RD.
REQ-028 POLL_RD: one read, addr 0; POLL_CAP samples masterReadData the next cycle.
REQ-029 POLL_CAP: bit0 = 0 -> POLL_WAIT; bit0 = 1 -> latch found = bit1, go NONCE_RD.
REQ-030 NONCE_RD: one read, addr 10; NONCE_CAP latches masterReadData into foundNonce only when found = 1, else foundNonce stays 0.
REQ-031 FINISH: done high one cycle, busy low in the same cycle, return to IDLE; start in FINISH cycle is ignored.
REQ-032 Poll counter is 32 bits, saturating; no wrap-around.

Reset
REQ-033 n_rst low -> state IDLE; busy, done, found, timeout, foundNonce, all master strobes, masterAddr, and masterWriteData at 0, immediately and asynchronously.
REQ-034 Reset mid-job aborts without any further bus cycle; after release the block accepts a new start.

Configuration
REQ-035 MINER_HOST_TIMEOUT_EN defined: in POLL_CAP with complete = 0 and poll count = TIMEOUT_POLLS -> write addr 1 = 0, set timeout = 1 and found = 0, go FINISH.
REQ-036 MINER_HOST_TIMEOUT_EN undefined: polling unbounded, timeout tied 0, TIMEOUT_POLLS unused.

Verification
REQ-037 start with target = 0xFF..FF, message = incrementing words, slave model replies complete+found on the first poll, nonce 0x0000_002A -> 29 writes in the REQ-019 order, done pulse, found = 1, foundNonce = 0x2A.
REQ-038 Slave model returns status 0x1 (complete, not found) on the 3rd poll -> exactly 3 addr-0 reads spaced POLL_INTERVAL+2 cycles apart, then one addr-10 read, found = 0, foundNonce = 0.
REQ-039 start pulsed again 5 cycles into a job -> no restart, write sequence and captured data unchanged.
REQ-040 n_rst asserted during WR_MSG at addr 17 -> all strobes 0 the same cycle; a new start then begins again at CLR_CTRL.
REQ-041 MINER_HOST_TIMEOUT_EN, TIMEOUT_POLLS = 4, status always 0 -> 4 reads, a write of addr 1 = 0, done, timeout = 1, found = 0.
REQ-042 Every cycle: masterChipSelect = masterWrite | masterRead, and masterWrite and masterRead are never high together.

Source files
------------

// File: rtl/miner_host_master.sv
// Avalon host that loads a mining job (target + header) into a miner, polls status, reads the nonce.
// Write phase is 29 back-to-back cycles, no slave backpressure; MINER_HOST_TIMEOUT_EN adds a poll watchdog.
module miner_host_master #(
    parameter int POLL_INTERVAL = 16,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [255:0] target,
    input  logic [607:0] message,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         timeout,
    output logic [31:0]  foundNonce,
    output logic [4:0]   masterAddr,
    output logic [31:0]  masterWriteData,
    output logic         masterWrite,
    output logic         masterRead,
    output logic         masterChipSelect,
    input  logic [31:0]  masterReadData
);

    typedef enum logic [3:0] {
        IDLE, CLR_CTRL, WR_TARGET, WR_MSG, SET_CTRL,
        POLL_WAIT, POLL_RD, POLL_CAP, NONCE_RD, NONCE_CAP, FINISH
    } state_t;

    localparam logic [31:0] WAIT_LAST = 32'(POLL_INTERVAL - 1);

    state_t         state;
    logic [255:0]   tgt_q;
    logic [607:0]   msg_q;
    logic [4:0]     idx;
    logic [31:0]    wait_cnt;
    logic [31:0]    poll_cnt;

`ifdef MINER_HOST_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_POLLS);
    logic timeout_q;
    assign timeout = timeout_q;
`else
    logic [31:0] unused_poll_cnt;
    assign unused_poll_cnt = poll_cnt ^ 32'(TIMEOUT_POLLS);
    assign timeout = 1'b0;
`endif

    assign masterChipSelect = masterWrite | masterRead;

    // Bus outputs are registered: each branch sets up the strobes for the state being entered.
    // The job copies are shifted out word by word, so the low 32 bits are always the next word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            tgt_q           <= '0;
            msg_q           <= '0;
            idx             <= '0;
            wait_cnt        <= '0;
            poll_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            found           <= 1'b0;
            foundNonce      <= '0;
            masterAddr      <= '0;
            masterWriteData <= '0;
            masterWrite     <= 1'b0;
            masterRead      <= 1'b0;
`ifdef MINER_HOST_TIMEOUT_EN
            timeout_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q           <= target;
                        msg_q           <= message;
                        found           <= 1'b0;
                        foundNonce      <= '0;
                        poll_cnt        <= '0;
                        busy            <= 1'b1;
                        masterWrite     <= 1'b1;
                        masterAddr      <= 5'd1;
                        masterWriteData <= '0;
`ifdef MINER_HOST_TIMEOUT_EN
                        timeout_q       <= 1'b0;
`endif
                        state           <= CLR_CTRL;
                    end
                end
                CLR_CTRL: begin
                    masterAddr      <= 5'd2;
                    masterWriteData <= tgt_q[31:0];
                    tgt_q           <= tgt_q >> 32;
                    idx             <= '0;
                    state           <= WR_TARGET;
                end
                WR_TARGET: begin
                    if (idx == 5'd7) begin
                        masterAddr      <= 5'd11;
                        masterWriteData <= msg_q[31:0];
                        msg_q           <= msg_q >> 32;
                        idx             <= '0;
                        state           <= WR_MSG;
                    end else begin
                        masterAddr      <= masterAddr + 5'd1;
                        masterWriteData <= tgt_q[31:0];
                        tgt_q           <= tgt_q >> 32;
                        idx             <= idx + 5'd1;
                    end
                end
                WR_MSG: begin
                    if (idx == 5'd18) begin
                        masterAddr      <= 5'd1;
                        masterWriteData <= 32'd3;
                        state           <= SET_CTRL;
                    end else begin
                        masterAddr      <= masterAddr + 5'd1;
                        masterWriteData <= msg_q[31:0];
                        msg_q           <= msg_q >> 32;
                        idx             <= idx + 5'd1;
                    end
                end
                SET_CTRL: begin
                    masterWrite     <= 1'b0;
                    masterAddr      <= '0;
                    masterWriteData <= '0;
                    wait_cnt        <= '0;
                    state           <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        masterRead <= 1'b1;
                        masterAddr <= 5'd0;
                        state      <= POLL_RD;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                POLL_RD: begin
                    masterRead <= 1'b0;
                    if (poll_cnt != '1)
                        poll_cnt <= poll_cnt + 32'd1;
                    state <= POLL_CAP;
                end
                POLL_CAP: begin
                    if (masterReadData[0]) begin
                        found      <= masterReadData[1];
                        masterRead <= 1'b1;
                        masterAddr <= 5'd10;
                        state      <= NONCE_RD;
                    end
`ifdef MINER_HOST_TIMEOUT_EN
                    else if (poll_cnt == TIMEOUT_LIM) begin
                        // Drop the control bits so the miner stops; the write lands in FINISH.
                        masterWrite     <= 1'b1;
                        masterAddr      <= 5'd1;
                        masterWriteData <= '0;
                        timeout_q       <= 1'b1;
                        found           <= 1'b0;
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        state           <= FINISH;
                    end
`endif
                    else begin
                        wait_cnt <= '0;
                        state    <= POLL_WAIT;
                    end
                end
                NONCE_RD: begin
                    masterRead <= 1'b0;
                    masterAddr <= '0;
                    state      <= NONCE_CAP;
                end
                NONCE_CAP: begin
                    if (found)
                        foundNonce <= masterReadData;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FINISH;
                end
                FINISH: begin
                    masterWrite     <= 1'b0;
                    masterRead      <= 1'b0;
                    masterAddr      <= '0;
                    masterWriteData <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
